// File: rtl/hazard_pkg.sv
// Shared encodings and per-class latency/threshold constants for the hazard scoreboard.
package hazard_pkg;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'b00,
        CLS_LOAD   = 2'b01,
        CLS_MATRIX = 2'b10,
        CLS_RSVD   = 2'b11
    } id_class_e;

    localparam logic [1:0] FWD_ID_EX  = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    localparam int L_ALU  = 3;
    localparam int L_LOAD = 3;
    localparam logic [1:0] T_ALU    = 2'd3;
    localparam logic [1:0] T_LOAD   = 2'd2;
    localparam logic [1:0] T_MATRIX = 2'd3;

    // Cycles until the producer leaves WB, counted from the cycle after issue.
    function automatic int class_lat(input logic [1:0] cls, input int mat_lat);
        case (id_class_e'(cls))
            CLS_LOAD:   return L_LOAD;
            CLS_MATRIX: return mat_lat + 2;
            default:    return L_ALU;
        endcase
    endfunction

    function automatic logic [1:0] class_thr(input logic [1:0] cls);
        case (id_class_e'(cls))
            CLS_LOAD:   return T_LOAD;
            CLS_MATRIX: return T_MATRIX;
            default:    return T_ALU;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: busy flag, countdown to WB exit, and the producer's ready threshold.
module sb_entry #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic [1:0]       load_thr,
    output logic             busy,
    output logic [CNT_W-1:0] cnt,
    output logic [1:0]       thr
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= 1'b0;
            cnt  <= '0;
            thr  <= '0;
        end else if (load) begin
            // A new producer wins over the decrement and replaces both cnt and threshold.
            busy <= 1'b1;
            cnt  <= load_cnt;
            thr  <= load_thr;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stalls on load-use, matrix and WAW hazards, registers forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_XREGS = 32,
    parameter int NUM_MREGS = 4,
    parameter int MAT_LAT   = 4,
    parameter int CNT_W     = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           id_valid,
    input  logic [4:0]                     id_rs1,
    input  logic [4:0]                     id_rs2,
    input  logic                           id_rs1_m,
    input  logic                           id_rs2_m,
    input  logic                           id_rs1_used,
    input  logic                           id_rs2_used,
    input  logic [4:0]                     id_rd,
    input  logic                           id_rd_m,
    input  logic                           id_wen,
    input  logic [1:0]                     id_class,
    input  logic                           flush,
    output logic                           stall,
    output logic [1:0]                     fwd_a,
    output logic [1:0]                     fwd_b,
    output logic [NUM_XREGS+NUM_MREGS-1:0] busy_vec
);

    localparam int NR    = NUM_XREGS + NUM_MREGS;
    localparam int IDX_W = $clog2(NR);
    localparam int MI_W  = (NUM_MREGS > 1) ? $clog2(NUM_MREGS) : 1;

    logic [NR-1:0]    busy_w;
    logic [CNT_W-1:0] cnt_w [NR];
    logic [1:0]       thr_w [NR];

    logic [IDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [CNT_W-1:0] new_l;
    logic [1:0]       new_t;
    logic             rd_writes, raw1, raw2, waw, accept, ld_en;
    logic [1:0]       sel_a, sel_b;

    function automatic logic [IDX_W-1:0] map_idx(input logic [4:0] r, input logic m);
        return m ? IDX_W'(NUM_XREGS) + IDX_W'(r[MI_W-1:0]) : IDX_W'(r);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic b, input logic [CNT_W-1:0] c);
        return (b && c == CNT_W'(3)) ? FWD_EX_MEM :
               (b && c == CNT_W'(2)) ? FWD_MEM_WB : FWD_ID_EX;
    endfunction

    assign rs1_idx = map_idx(id_rs1, id_rs1_m);
    assign rs2_idx = map_idx(id_rs2, id_rs2_m);
    assign rd_idx  = map_idx(id_rd, id_rd_m);

    assign new_l     = CNT_W'(class_lat(id_class, MAT_LAT));
    assign new_t     = class_thr(id_class);
    assign rd_writes = id_wen && !(id_rd == 5'd0 && !id_rd_m);

    assign raw1 = id_rs1_used && busy_w[rs1_idx] && (cnt_w[rs1_idx] > CNT_W'(thr_w[rs1_idx]));
    assign raw2 = id_rs2_used && busy_w[rs2_idx] && (cnt_w[rs2_idx] > CNT_W'(thr_w[rs2_idx]));
    // Only stall WAW when the older write would land after the new one.
    assign waw  = rd_writes && busy_w[rd_idx] && (cnt_w[rd_idx] > new_l);

    assign stall  = id_valid && !flush && (raw1 || raw2 || waw);
    assign accept = id_valid && !stall && !flush;
    assign ld_en  = accept && rd_writes;

    assign sel_a = fwd_sel(busy_w[rs1_idx], cnt_w[rs1_idx]);
    assign sel_b = fwd_sel(busy_w[rs2_idx], cnt_w[rs2_idx]);

    for (genvar g = 0; g < NR; g++) begin : g_ent
        if (g == 0) begin : g_tie
            assign busy_w[g] = 1'b0;
            assign cnt_w[g]  = '0;
            assign thr_w[g]  = '0;
        end else begin : g_sb
            sb_entry #(.CNT_W(CNT_W)) u_ent (
                .clk      (clk),
                .rstn     (rstn),
                .load     (ld_en && (rd_idx == IDX_W'(g))),
                .load_cnt (new_l),
                .load_thr (new_t),
                .busy     (busy_w[g]),
                .cnt      (cnt_w[g]),
                .thr      (thr_w[g])
            );
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd_a <= FWD_ID_EX;
            fwd_b <= FWD_ID_EX;
        end else if (accept) begin
            fwd_a <= sel_a;
            fwd_b <= sel_b;
        end else begin
            fwd_a <= FWD_ID_EX;
            fwd_b <= FWD_ID_EX;
        end
    end

    assign busy_vec = busy_w;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random stimulus for hazard_scoreboard against a time-stamp based reference model.
module tb_hazard_scoreboard;

    localparam int NX = 32, NM = 4, MAT_LAT = 4, NR = NX + NM;

    logic clk = 1'b0, rstn = 1'b0;
    logic id_valid, id_rs1_m, id_rs2_m, id_rs1_used, id_rs2_used, id_rd_m, id_wen, flush;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] id_class, fwd_a, fwd_b;
    logic stall;
    logic [NR-1:0] busy_vec;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_XREGS(NX), .NUM_MREGS(NM), .MAT_LAT(MAT_LAT), .CNT_W(4)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_m(id_rs1_m), .id_rs2_m(id_rs2_m),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_m(id_rd_m), .id_wen(id_wen), .id_class(id_class),
        .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .busy_vec(busy_vec)
    );

    typedef struct {
        logic v; logic [1:0] cls; logic [4:0] rd; logic rdm; logic wen;
        logic [4:0] rs1; logic rs1m; logic rs1u; logic [4:0] rs2; logic rs2m; logic rs2u;
    } ins_t;

    // Model: each register remembers the cycle its latest producer leaves WB and its threshold.
    int cyc = 0;
    int end_c [NR];
    int mthr  [NR];
    logic [1:0] exp_fa = 2'b00, exp_fb = 2'b00;
    bit exp_stall = 0;
    int vectors = 0, miscompares = 0;

    function automatic ins_t mk(bit v, int cls, int rd, bit rdm, bit wen,
                                int rs1, bit rs1m, bit rs1u, int rs2, bit rs2m, bit rs2u);
        ins_t i;
        i.v = v; i.cls = 2'(cls); i.rd = 5'(rd); i.rdm = rdm; i.wen = wen;
        i.rs1 = 5'(rs1); i.rs1m = rs1m; i.rs1u = rs1u;
        i.rs2 = 5'(rs2); i.rs2m = rs2m; i.rs2u = rs2u;
        return i;
    endfunction

    function automatic int idx(logic [4:0] r, logic m);
        return m ? NX + (int'(r) % NM) : int'(r);
    endfunction
    function automatic int lat(logic [1:0] c);
        return (c == 2'd2) ? MAT_LAT + 2 : 3;
    endfunction
    function automatic int thr(logic [1:0] c);
        return (c == 2'd1) ? 2 : 3;
    endfunction
    function automatic int mcnt(int r);
        int d;
        d = end_c[r] - cyc;
        return (d > 0) ? d : 0;
    endfunction
    function automatic logic [1:0] fsel(int c);
        return (c == 3) ? 2'b10 : (c == 2) ? 2'b01 : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < NR; r++) begin end_c[r] = 0; mthr[r] = 0; end
        exp_fa = 2'b00; exp_fb = 2'b00;
    endtask

    task automatic drive(input ins_t i, input bit fl);
        id_valid = i.v; id_class = i.cls; id_rd = i.rd; id_rd_m = i.rdm; id_wen = i.wen;
        id_rs1 = i.rs1; id_rs1_m = i.rs1m; id_rs1_used = i.rs1u;
        id_rs2 = i.rs2; id_rs2_m = i.rs2m; id_rs2_used = i.rs2u;
        flush = fl;
    endtask

    // Drive one instruction for one cycle, check at negedge, advance the model at posedge.
    task automatic step(input ins_t i, input bit fl);
        int a, b, d;
        bit wr, acc;
        logic [1:0] sa, sb;
        logic [NR-1:0] bv;
        drive(i, fl);
        @(negedge clk);
        a = idx(i.rs1, i.rs1m); b = idx(i.rs2, i.rs2m); d = idx(i.rd, i.rdm);
        wr = i.wen && !(i.rd == 0 && !i.rdm);
        exp_stall = i.v && !fl && ((i.rs1u && mcnt(a) > mthr[a]) ||
                                   (i.rs2u && mcnt(b) > mthr[b]) ||
                                   (wr && mcnt(d) > lat(i.cls)));
        acc = i.v && !fl && !exp_stall;
        for (int r = 0; r < NR; r++) bv[r] = (mcnt(r) > 0);
        chk("stall", 64'(stall), 64'(exp_stall));
        chk("fwd_a", 64'(fwd_a), 64'(exp_fa));
        chk("fwd_b", 64'(fwd_b), 64'(exp_fb));
        chk("busy_vec", 64'(busy_vec), 64'(bv));
        sa = fsel(mcnt(a)); sb = fsel(mcnt(b));
        @(posedge clk);
        if (acc) begin
            exp_fa = sa; exp_fb = sb;
            if (wr) begin end_c[d] = cyc + lat(i.cls) + 1; mthr[d] = thr(i.cls); end
        end else begin
            exp_fa = 2'b00; exp_fb = 2'b00;
        end
        cyc++;
        #1;
    endtask

    ins_t nop, cur;
    bit fl;

    initial begin
        clear_model();
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(nop, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_fwd_a", 64'(fwd_a), 64'd0);
        chk("rst_fwd_b", 64'(fwd_b), 64'd0);
        chk("rst_busy", 64'(busy_vec), 64'd0);
        rstn = 1'b1;

        // ALU x5 -> reader of x5 (EX_MEM), then another reader (MEM_WB)
        step(mk(1, 0, 5, 0, 1, 1, 0, 1, 2, 0, 1), 0);
        step(mk(1, 0, 8, 0, 1, 5, 0, 1, 0, 0, 0), 0);
        step(mk(1, 0, 9, 0, 1, 5, 0, 1, 0, 0, 0), 0);
        repeat (3) step(nop, 0);

        // LOAD x6 -> use rs2=x6: one stall cycle
        step(mk(1, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        repeat (2) step(mk(1, 0, 10, 0, 1, 0, 0, 0, 6, 0, 1), 0);
        repeat (4) step(nop, 0);

        // MATRIX m1 -> reader of m1: three stall cycles
        step(mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0), 0);
        repeat (4) step(mk(1, 0, 11, 0, 1, 1, 1, 1, 0, 0, 0), 0);
        repeat (6) step(nop, 0);

        // rd=x0 writer then x0 reader
        step(mk(1, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0), 0);
        step(mk(1, 1, 12, 0, 1, 0, 0, 1, 0, 0, 1), 0);
        repeat (4) step(nop, 0);

        // MATRIX-class write of x7 then ALU write of x7: WAW
        step(mk(1, 2, 7, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        repeat (4) step(mk(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        repeat (5) step(nop, 0);

        // LOAD x6 + stalled dependent, then flush
        step(mk(1, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        step(mk(1, 0, 13, 0, 1, 6, 0, 1, 0, 0, 0), 0);
        step(mk(1, 0, 13, 0, 1, 6, 0, 1, 0, 0, 0), 1);
        step(nop, 0);

        // Async reset with three busy entries and a stalled dependent in ID
        step(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        step(mk(1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        step(mk(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        drive(mk(1, 0, 4, 0, 1, 3, 0, 1, 0, 0, 0), 0);
        #2;
        chk("pre_rst_stall", 64'(stall), 64'd1);
        rstn = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy_vec), 64'd0);
        chk("async_rst_stall", 64'(stall), 64'd0);
        chk("async_rst_fwd_a", 64'(fwd_a), 64'd0);
        clear_model();
        @(posedge clk);
        cyc++;
        #1;
        rstn = 1'b1;

        // Random phase: small register pool to provoke hazards; stalled instructions are held
        cur = nop;
        for (int n = 0; n < 400; n++) begin
            if (!exp_stall || fl) begin
                cur = mk(($urandom_range(0, 7) != 0), $urandom_range(0, 3),
                         $urandom_range(0, 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                         $urandom_range(0, 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                         $urandom_range(0, 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
            end
            fl = ($urandom_range(0, 9) == 0);
            step(cur, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
